// File: rtl/rggen_avalon_pipeline_bridge_if.sv
// Host-side and command-side bus bundles for rggen_avalon_pipeline_bridge.
// Signal names are written from the bridge's point of view (i_ = into the bridge).
`timescale 1ns/1ps

interface rggen_avalon_pipeline_bridge_host_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       i_host_read;
    logic                       i_host_write;
    logic [ADDRESS_WIDTH-1:0]   i_host_address;
    logic [BUS_WIDTH/8-1:0]     i_host_byteenable;
    logic [BUS_WIDTH-1:0]       i_host_writedata;
    logic                       o_host_waitrequest;
    logic                       o_host_readdatavalid;
    logic                       o_host_writeresponsevalid;
    logic [1:0]                 o_host_response;
    logic [BUS_WIDTH-1:0]       o_host_readdata;

    modport master (
        output i_host_read, i_host_write, i_host_address, i_host_byteenable, i_host_writedata,
        input  o_host_waitrequest, o_host_readdatavalid, o_host_writeresponsevalid,
        input  o_host_response, o_host_readdata
    );

    modport slave (
        input  i_host_read, i_host_write, i_host_address, i_host_byteenable, i_host_writedata,
        output o_host_waitrequest, o_host_readdatavalid, o_host_writeresponsevalid,
        output o_host_response, o_host_readdata
    );
endinterface

interface rggen_avalon_pipeline_bridge_cmd_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                       o_read;
    logic                       o_write;
    logic [ADDRESS_WIDTH-1:0]   o_address;
    logic [BUS_WIDTH/8-1:0]     o_byteenable;
    logic [BUS_WIDTH-1:0]       o_writedata;
    logic                       i_waitrequest;
    logic [1:0]                 i_response;
    logic [BUS_WIDTH-1:0]       i_readdata;

    modport master (
        output o_read, o_write, o_address, o_byteenable, o_writedata,
        input  i_waitrequest, i_response, i_readdata
    );

    modport slave (
        input  o_read, o_write, o_address, o_byteenable, o_writedata,
        output i_waitrequest, i_response, i_readdata
    );
endinterface

// File: rtl/rggen_avalon_pipeline_bridge.sv
// Pipelined Avalon-MM host -> command FIFO -> one-at-a-time waitrequest command port.
// Optional macro RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN enables host write responses.
`timescale 1ns/1ps

module rggen_avalon_pipeline_bridge #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int DEPTH         = 4
) (
    input logic                                 i_clk,
    input logic                                 i_rst_n,
    rggen_avalon_pipeline_bridge_host_if.slave  host_if,
    rggen_avalon_pipeline_bridge_cmd_if.master  cmd_if
);

    localparam int BE_WIDTH  = BUS_WIDTH / 8;
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic                       r_fifo_is_write   [DEPTH];
    logic [ADDRESS_WIDTH-1:0]   r_fifo_address    [DEPTH];
    logic [BE_WIDTH-1:0]        r_fifo_byteenable [DEPTH];
    logic [BUS_WIDTH-1:0]       r_fifo_writedata  [DEPTH];
    logic [PTR_WIDTH-1:0]       r_wr_ptr;
    logic [PTR_WIDTH-1:0]       r_rd_ptr;
    logic [CNT_WIDTH-1:0]       r_count;

    logic [0:0]                 r_state;
    logic                       r_read;
    logic                       r_write;
    logic                       r_cmd_is_write;
    logic [ADDRESS_WIDTH-1:0]   r_address;
    logic [BE_WIDTH-1:0]        r_byteenable;
    logic [BUS_WIDTH-1:0]       r_writedata;

    logic                       r_host_readdatavalid;
    logic [1:0]                 r_host_response;
    logic [BUS_WIDTH-1:0]       r_host_readdata;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_push_is_write;
    logic w_pop;
    logic w_cmd_active;
    logic w_complete;

    assign w_full          = (r_count == FULL_COUNT);
    assign w_empty         = (r_count == '0);
    assign w_push          = (host_if.i_host_read | host_if.i_host_write) & ~w_full;
    // A simultaneous read and write request is queued as a read.
    assign w_push_is_write = host_if.i_host_write & ~host_if.i_host_read;
    assign w_cmd_active    = r_read | r_write;
    assign w_complete      = w_cmd_active & ~cmd_if.i_waitrequest;
    assign w_pop           = ~w_empty & ((r_state == ST_IDLE) | w_complete);

    // NOTE: FIFO storage is pure datapath qualified by the count, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_is_write[r_wr_ptr]   <= w_push_is_write;
            r_fifo_address[r_wr_ptr]    <= host_if.i_host_address;
            r_fifo_byteenable[r_wr_ptr] <= host_if.i_host_byteenable;
            r_fifo_writedata[r_wr_ptr]  <= host_if.i_host_writedata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_pop) begin
            r_cmd_is_write <= r_fifo_is_write[r_rd_ptr];
            r_address      <= r_fifo_address[r_rd_ptr];
            r_byteenable   <= r_fifo_byteenable[r_rd_ptr];
            r_writedata    <= r_fifo_writedata[r_rd_ptr];
        end
    end

    // In BUSY with no strobe active, the next command was loaded on the previous
    // completion edge and is launched now, giving a one-cycle gap between commands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_BUSY;
                        r_read  <= ~r_fifo_is_write[r_rd_ptr];
                        r_write <= r_fifo_is_write[r_rd_ptr];
                    end
                end
                ST_BUSY: begin
                    if (w_cmd_active) begin
                        if (!cmd_if.i_waitrequest) begin
                            r_read  <= 1'b0;
                            r_write <= 1'b0;
                            if (w_empty) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else begin
                        r_read  <= ~r_cmd_is_write;
                        r_write <= r_cmd_is_write;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN
    logic r_host_writeresponsevalid;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_host_readdatavalid      <= 1'b0;
            r_host_response           <= 2'b00;
            r_host_readdata           <= '0;
`ifdef RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN
            r_host_writeresponsevalid <= 1'b0;
`endif
        end else begin
            r_host_readdatavalid <= w_complete & r_read;
`ifdef RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN
            r_host_writeresponsevalid <= w_complete & r_write;
`endif
            if (w_complete && r_read) begin
                r_host_response <= cmd_if.i_response;
                r_host_readdata <= cmd_if.i_readdata;
            end
`ifdef RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN
            else if (w_complete && r_write) begin
                r_host_response <= cmd_if.i_response;
            end
`endif
        end
    end

    assign host_if.o_host_waitrequest   = w_full;
    assign host_if.o_host_readdatavalid = r_host_readdatavalid;
    assign host_if.o_host_response      = r_host_response;
    assign host_if.o_host_readdata      = r_host_readdata;
`ifdef RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN
    assign host_if.o_host_writeresponsevalid = r_host_writeresponsevalid;
`else
    assign host_if.o_host_writeresponsevalid = 1'b0;
`endif

    assign cmd_if.o_read       = r_read;
    assign cmd_if.o_write      = r_write;
    assign cmd_if.o_address    = r_address;
    assign cmd_if.o_byteenable = r_byteenable;
    assign cmd_if.o_writedata  = r_writedata;

endmodule

// File: tb/tb_rggen_avalon_pipeline_bridge.sv
// Scoreboard bench for rggen_avalon_pipeline_bridge: commands and host responses are
// predicted at host acceptance and compared when the DUT produces them.
`timescale 1ns/1ps

module tb_rggen_avalon_pipeline_bridge;

    localparam int AW  = 8;
    localparam int BW  = 32;
    localparam int BEW = BW / 8;

    typedef struct {
        logic           is_write;
        logic [AW-1:0]  addr;
        logic [BEW-1:0] be;
        logic [BW-1:0]  wdata;
    } cmd_t;

    typedef struct {
        logic          is_write;
        logic [BW-1:0] data;
        logic [1:0]    resp;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rggen_avalon_pipeline_bridge_host_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) host_bus ();
    rggen_avalon_pipeline_bridge_cmd_if  #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) cmd_bus ();

    rggen_avalon_pipeline_bridge #(
        .ADDRESS_WIDTH(AW),
        .BUS_WIDTH(BW),
        .DEPTH(4)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .host_if(host_bus),
        .cmd_if(cmd_bus)
    );

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // Downstream responder: holds i_waitrequest high for dn_wait cycles of each command.
    int            dn_wait = 0;
    logic [BW-1:0] dn_base = '0;
    logic [1:0]    dn_resp = 2'b00;
    int            busy_cnt = 0;
    cmd_t          cur_cmd;
    cmd_t          exp_cmd;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
            cmd_bus.i_waitrequest = 1'b1;
            cmd_bus.i_response = 2'b00;
            cmd_bus.i_readdata = '0;
        end else if (cmd_bus.o_read || cmd_bus.o_write) begin
            if (busy_cnt == 0) begin
                cur_cmd = '{cmd_bus.o_write, cmd_bus.o_address, cmd_bus.o_byteenable, cmd_bus.o_writedata};
                n_checks++;
                if (cmd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL dn_cmd: unexpected command rd=%b wr=%b addr=%h", cmd_bus.o_read, cmd_bus.o_write, cmd_bus.o_address);
                end else begin
                    exp_cmd = cmd_q.pop_front();
                    if (cmd_bus.o_write !== exp_cmd.is_write || cmd_bus.o_read !== !exp_cmd.is_write ||
                        cmd_bus.o_address !== exp_cmd.addr || cmd_bus.o_byteenable !== exp_cmd.be ||
                        (exp_cmd.is_write && cmd_bus.o_writedata !== exp_cmd.wdata)) begin
                        n_fail++;
                        $display("FAIL dn_cmd: got rd=%b wr=%b addr=%h be=%h wd=%h expected wr=%b addr=%h be=%h wd=%h",
                                 cmd_bus.o_read, cmd_bus.o_write, cmd_bus.o_address, cmd_bus.o_byteenable, cmd_bus.o_writedata,
                                 exp_cmd.is_write, exp_cmd.addr, exp_cmd.be, exp_cmd.wdata);
                    end
                end
            end else begin
                n_checks++;
                if (cmd_bus.o_write !== cur_cmd.is_write || cmd_bus.o_address !== cur_cmd.addr ||
                    cmd_bus.o_byteenable !== cur_cmd.be || cmd_bus.o_writedata !== cur_cmd.wdata) begin
                    n_fail++;
                    $display("FAIL dn_hold: command changed while busy, addr=%h expected %h", cmd_bus.o_address, cur_cmd.addr);
                end
            end
            cmd_bus.i_waitrequest = (busy_cnt != dn_wait);
            cmd_bus.i_readdata = dn_base ^ BW'(cmd_bus.o_address);
            cmd_bus.i_response = dn_resp;
            busy_cnt++;
        end else begin
            busy_cnt = 0;
            cmd_bus.i_waitrequest = 1'b1;
        end
    end

    // Host response monitor: every strobe must match the head of the response queue.
    rsp_t exp_rsp;
    always @(negedge clk) begin
        if (rst_n && (host_bus.o_host_readdatavalid || host_bus.o_host_writeresponsevalid)) begin
            n_checks++;
            if (rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL host_rsp: unexpected strobe rdv=%b wrv=%b", host_bus.o_host_readdatavalid, host_bus.o_host_writeresponsevalid);
            end else begin
                exp_rsp = rsp_q.pop_front();
                if (host_bus.o_host_readdatavalid !== !exp_rsp.is_write ||
                    host_bus.o_host_writeresponsevalid !== exp_rsp.is_write ||
                    host_bus.o_host_response !== exp_rsp.resp ||
                    (!exp_rsp.is_write && host_bus.o_host_readdata !== exp_rsp.data)) begin
                    n_fail++;
                    $display("FAIL host_rsp: got rdv=%b wrv=%b resp=%b data=%h expected write=%b resp=%b data=%h",
                             host_bus.o_host_readdatavalid, host_bus.o_host_writeresponsevalid, host_bus.o_host_response,
                             host_bus.o_host_readdata, exp_rsp.is_write, exp_rsp.resp, exp_rsp.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; holds the request until accepted and returns at the next negedge.
    task automatic host_issue(input logic rd, input logic wr, input logic [AW-1:0] addr,
                              input logic [BEW-1:0] be, input logic [BW-1:0] wd, output int waited);
        bit acc = 1'b0;
        waited = 0;
        host_bus.i_host_read = rd;
        host_bus.i_host_write = wr;
        host_bus.i_host_address = addr;
        host_bus.i_host_byteenable = be;
        host_bus.i_host_writedata = wd;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (!host_bus.o_host_waitrequest) begin
                acc = 1'b1;
                cmd_q.push_back('{wr & ~rd, addr, be, wd});
                if (rd) begin
                    rsp_q.push_back('{1'b0, dn_base ^ BW'(addr), dn_resp});
                end else begin
`ifdef RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN
                    rsp_q.push_back('{1'b1, '0, dn_resp});
`endif
                end
            end else begin
                waited++;
            end
            @(negedge clk);
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL host_accept: request at addr %h never accepted", addr);
        end
    endtask

    task automatic host_idle();
        host_bus.i_host_read = 1'b0;
        host_bus.i_host_write = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = (cmd_q.size() == 0) && (rsp_q.size() == 0) && !cmd_bus.o_read && !cmd_bus.o_write;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: pending cmds=%0d rsps=%0d, required 0/0", name, cmd_q.size(), rsp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        host_idle();
        host_bus.i_host_address = '0;
        host_bus.i_host_byteenable = '0;
        host_bus.i_host_writedata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({host_bus.o_host_waitrequest, host_bus.o_host_readdatavalid, host_bus.o_host_writeresponsevalid,
             cmd_bus.o_read, cmd_bus.o_write, host_bus.o_host_response, host_bus.o_host_readdata} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_hold: wreq=%b rdv=%b wrv=%b rd=%b wr=%b resp=%b data=%h, required all 0",
                     host_bus.o_host_waitrequest, host_bus.o_host_readdatavalid, host_bus.o_host_writeresponsevalid,
                     cmd_bus.o_read, cmd_bus.o_write, host_bus.o_host_response, host_bus.o_host_readdata);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({host_bus.o_host_waitrequest, host_bus.o_host_readdatavalid, host_bus.o_host_writeresponsevalid,
             cmd_bus.o_read, cmd_bus.o_write, host_bus.o_host_response, host_bus.o_host_readdata} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_release: wreq=%b rdv=%b rd=%b wr=%b resp=%b data=%h, required all 0",
                     host_bus.o_host_waitrequest, host_bus.o_host_readdatavalid, cmd_bus.o_read, cmd_bus.o_write,
                     host_bus.o_host_response, host_bus.o_host_readdata);
        end
    endtask

    // Accepted in cycle T: o_read in T+2..T+3, completion in T+3, readdatavalid in T+4.
    task automatic test_single_read();
        int w;
        logic [4:0] seen;
        dn_wait = 1;
        dn_base = 32'hA5A5_0001;
        dn_resp = 2'b00;
        host_issue(1'b1, 1'b0, 8'h00, 4'hF, '0, w);
        host_idle();
        seen[0] = cmd_bus.o_read;
        @(negedge clk); seen[1] = cmd_bus.o_read;
        @(negedge clk); seen[2] = cmd_bus.o_read;
        @(negedge clk); seen[3] = cmd_bus.o_read; seen[4] = host_bus.o_host_readdatavalid;
        n_checks++;
        if (seen !== 5'b10110) begin
            n_fail++;
            $display("FAIL single_read_timing: o_read T+1..T+4 / rdv T+4 = %b, required 10110", seen);
        end
        n_checks++;
        if (host_bus.o_host_readdata !== 32'hA5A5_0001 || host_bus.o_host_response !== 2'b00) begin
            n_fail++;
            $display("FAIL single_read_data: got %h/%b required a5a50001/00", host_bus.o_host_readdata, host_bus.o_host_response);
        end
        @(negedge clk);
        n_checks++;
        if (host_bus.o_host_readdatavalid !== 1'b0 || host_bus.o_host_readdata !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL single_read_hold: rdv=%b data=%h required 0/a5a50001", host_bus.o_host_readdatavalid, host_bus.o_host_readdata);
        end
        wait_drain("single_read");
    endtask

    // The head is popped into the command register one cycle after the first accept, so
    // five reads fit without stalling and the sixth sees waitrequest.
    task automatic test_back_to_back();
        int w;
        dn_wait = 10;
        dn_base = 32'h1234_5600;
        dn_resp = 2'b01;
        for (int i = 0; i < 5; i++) begin
            host_issue(1'b1, 1'b0, AW'(i * 4), 4'hF, '0, w);
            n_checks++;
            if (w != 0) begin
                n_fail++;
                $display("FAIL b2b_accept_%0d: stalled %0d cycles, required 0", i, w);
            end
        end
        host_bus.i_host_address = 8'h14;
        n_checks++;
        if (host_bus.o_host_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_full: waitrequest=%b with FIFO full, required 1", host_bus.o_host_waitrequest);
        end
        host_issue(1'b1, 1'b0, 8'h14, 4'hF, '0, w);
        host_idle();
        n_checks++;
        if (w == 0) begin
            n_fail++;
            $display("FAIL b2b_stall: sixth read stalled %0d cycles, required >0", w);
        end
        wait_drain("b2b");
    endtask

    task automatic test_write();
        int w;
        dn_wait = 2;
        dn_resp = 2'b10;
        host_issue(1'b0, 1'b1, 8'h10, 4'b0011, 32'h0000_BEEF, w);
        host_idle();
        wait_drain("write");
        n_checks++;
`ifdef RGGEN_AVALON_BRIDGE_WRITE_RESPONSE_EN
        if (host_bus.o_host_response !== 2'b10 || host_bus.o_host_readdata !== 32'h1234_5614) begin
            n_fail++;
            $display("FAIL write_resp: resp=%b data=%h required 10/12345614", host_bus.o_host_response, host_bus.o_host_readdata);
        end
`else
        if (host_bus.o_host_response !== 2'b01 || host_bus.o_host_readdata !== 32'h1234_5614) begin
            n_fail++;
            $display("FAIL write_posted: resp=%b data=%h required 01/12345614", host_bus.o_host_response, host_bus.o_host_readdata);
        end
`endif
    endtask

    task automatic test_wrap();
        int w;
        int total = 0;
        dn_wait = 0;
        dn_base = 32'hC0DE_0000;
        dn_resp = 2'b00;
        for (int i = 0; i < 16; i++) begin
            host_issue(1'b1, 1'b0, AW'(8'h40 + i * 4), 4'hF, '0, w);
            total += w;
        end
        host_idle();
        n_checks++;
        if (total == 0) begin
            n_fail++;
            $display("FAIL wrap_full: host stalled %0d cycles, required >0 (FIFO never filled)", total);
        end
        wait_drain("wrap");
    endtask

    task automatic test_read_write_together();
        int w;
        dn_wait = 1;
        dn_base = 32'h0BAD_F000;
        dn_resp = 2'b11;
        host_issue(1'b1, 1'b1, 8'h20, 4'hF, 32'hDEAD_BEEF, w);
        host_idle();
        wait_drain("rd_wr");
    endtask

    task automatic test_reset_midop();
        int w;
        dn_wait = 40;
        dn_base = 32'h5555_0000;
        dn_resp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            host_issue(1'b1, 1'b0, AW'(8'h30 + i * 4), 4'hF, '0, w);
        end
        host_idle();
        n_checks++;
        if (cmd_bus.o_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_busy: o_read=%b before reset, required 1", cmd_bus.o_read);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cmd_bus.o_read !== 1'b0 || cmd_bus.o_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_drop: rd=%b wr=%b required 0/0", cmd_bus.o_read, cmd_bus.o_write);
        end
        cmd_q.delete();
        rsp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (host_bus.o_host_waitrequest !== 1'b0 || cmd_bus.o_read !== 1'b0 || cmd_bus.o_write !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: wreq=%b rd=%b wr=%b required 0/0/0",
                     host_bus.o_host_waitrequest, cmd_bus.o_read, cmd_bus.o_write);
        end
        dn_wait = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_wrap();
        test_read_write_together();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
